prog_fetch_unit: RTL and testbench
==================================

Name: prog_fetch_unit

Overview:
- Parametrised instruction fetch stage: an internal program RAM, loaded through a write port, is streamed out one instruction per accepted handshake.
- Successor to the fixed 9-byte shift-out fetch. Adds configurable width and depth, a runtime program end, jumps, wrap/halt mode, ready/valid back-pressure and an issued-instruction counter.
- Sits between program loader and decoder.

Parameters:
- INSTR_W, 8, instruction width in bits.
- DEPTH, 16, program RAM entries (power of two, at least 2).
- PC_W, $clog2(DEPTH), address width.
- WRAP, 0, end-of-program mode: 1 = wrap to 0 and keep running; 0 = halt and assert done.
- CNT_W, 16, issued-counter width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  program RAM write strobe.
- wr_addr  in  PC_W  write address.
- wr_data  in  INSTR_W  write data.
- prog_last  in  PC_W  address of the last program instruction; sampled on start.
- start  in  1  begin fetching at address 0.
- jump_en  in  1  redirect the next fetch.
- jump_addr  in  PC_W  jump target.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  PC_W  address of instr.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  consumer accepts instr.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  program finished (WRAP=0 only); sticky.
- issued  out  CNT_W  accepted-instruction count; saturates at all-ones.

Behaviour:
- Reset values: state IDLE; pc, instr, instr_pc, issued = 0; instr_valid, busy, done = 0. Reset is asynchronous and may occur in any state. RAM contents are not reset and survive rst.
- RAM: 1 write, 1 read, synchronous. A same-cycle read and write to one address returns the old data (read-before-write). Writes are legal in every state.
- Internal signals:
  - last_q: prog_last latched at start.
  - advance = !instr_valid || instr_ready.
  - fa (fetch address) = jump_en ? jump_addr : pc.
- State IDLE:
  - start → pc=0, last_q=prog_last, done=0, issued=0, go to RUN.
  - Other inputs ignored.
- State RUN (busy=1), when advance:
  - instr=mem[fa], instr_pc=fa, instr_valid=1.
  - If fa==last_q: WRAP=1 → pc=0; WRAP=0 → go to DRAIN.
  - Otherwise pc=fa+1.
  - Net effect: one instruction per cycle while ready is high. Latency from start to first valid is 1 cycle.
- Stall (instr_valid && !instr_ready): instr, instr_pc, instr_valid and pc hold. jump_en is ignored, not queued.
- State DRAIN: on instr_ready, instr_valid=0, done=1, go to DONE. jump_en is ignored.
- State DONE: done holds at 1. start restarts exactly as from IDLE.
- start while in RUN or DRAIN: ignored.
- issued increments on every cycle with instr_valid && instr_ready. It stops at 2^CNT_W-1.
- Jump beyond last_q with WRAP=0: fetching continues sequentially to DEPTH-1, then pc wraps to 0 until the address reaches last_q.
- Jump is legal with WRAP=1 and targets any address.
- prog_last=0 with WRAP=0: a single instruction is issued, then done.

Decomposition:
- Shared package fetch_pkg holds the state encoding (IDLE, RUN, DRAIN, DONE) and the default width constants.
- One sub-module, prog_ram: parametrised INSTR_W × DEPTH synchronous 1W1R RAM with read-before-write.
- FSM, pc logic and counter stay in prog_fetch_unit.

Test Plan:
- Load mem[i]=8'h10+i for i=0..15, prog_last=3, WRAP=0, ready=1, start → instr 10,11,12,13 on consecutive cycles, instr_pc 0..3; done=1 one cycle after the last handshake; issued=4; busy=0.
- Same program with ready toggling 1,0,0,1 → each instruction is held stable while ready=0, with no duplicates or skips; issued=4 at done.
- prog_last=15, WRAP=1, ready=1 for 20 cycles → sequence wraps 1F→10; issued=20; done stays 0.
- Pulse jump_en with jump_addr=9 in the cycle instr_pc=1 is accepted → next instr_pc=9 (instr 19), then 10. Jump asserted during a stall → ignored.
- Write mem[2]=8'hAA in the same cycle address 2 is fetched → old value 12 is output. A refetch after restart returns AA.
- Assert rst in mid-RUN → all outputs return to reset values immediately (asynchronously). RAM retains its contents; after start the sequence restarts from 0 with correct data.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared state encoding and default widths for prog_fetch_unit.
//  Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam int C_INSTR_W = 8;
    localparam int C_DEPTH   = 16;
    localparam int C_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/prog_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_fetch_unit_if
//  Brief    : Loader/consumer bus of the fetch unit (RAM write, control, issue).
//  Revision : 1.0
// ============================================================================
interface prog_fetch_unit_if #(
    parameter int INSTR_W = 8,
    parameter int PC_W    = 4,
    parameter int CNT_W   = 16
);
    logic               wr_en;
    logic [PC_W-1:0]    wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [PC_W-1:0]    prog_last;
    logic               start;
    logic               jump_en;
    logic [PC_W-1:0]    jump_addr;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   issued;

    modport master (
        output wr_en, wr_addr, wr_data, prog_last, start, jump_en, jump_addr, instr_ready,
        input  instr, instr_pc, instr_valid, busy, done, issued
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, prog_last, start, jump_en, jump_addr, instr_ready,
        output instr, instr_pc, instr_valid, busy, done, issued
    );
endinterface
`default_nettype wire

// File: rtl/prog_ram.sv
`default_nettype none
// ============================================================================
//  Module   : prog_ram
//  Brief    : Synchronous 1W1R program RAM, read-before-write, held read port.
//  Revision : 1.0
// ============================================================================
module prog_ram #(
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               wr_en_i,
    input  wire logic [AW-1:0]      wr_addr_i,
    input  wire logic [INSTR_W-1:0] wr_data_i,
    input  wire logic               rd_en_i,
    input  wire logic [AW-1:0]      rd_addr_i,
    output logic      [INSTR_W-1:0] rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    // Array is deliberately unreset so the program survives rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/prog_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : prog_fetch_unit
//  Brief    : Streams program RAM contents to the decoder under ready/valid.
//  Revision : 1.0
// ============================================================================
module prog_fetch_unit
    import fetch_pkg::*;
#(
    parameter int INSTR_W = C_INSTR_W,
    parameter int DEPTH   = C_DEPTH,
    parameter int PC_W    = $clog2(DEPTH),
    parameter int WRAP    = 0,
    parameter int CNT_W   = C_CNT_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    prog_fetch_unit_if.slave bus
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  last_q, last_d;
    logic [PC_W-1:0]  ipc_q, ipc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    logic             advance;
    logic             handshake;
    logic             fetch;
    logic [PC_W-1:0]  fa;

    assign advance   = !valid_q || bus.instr_ready;
    assign handshake = valid_q && bus.instr_ready;
    assign fa        = bus.jump_en ? bus.jump_addr : pc_q;
    assign fetch     = (state_q == ST_RUN) && advance;

    prog_ram #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .AW      (PC_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (fetch),
        .rd_addr_i (fa),
        .rd_data_o (bus.instr)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        last_d   = last_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        issued_d = issued_q;

        if (handshake && (issued_q != '1)) begin
            issued_d = issued_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    pc_d     = '0;
                    last_d   = bus.prog_last;
                    issued_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    ipc_d   = fa;
                    valid_d = 1'b1;
                    // pc wraps naturally past DEPTH-1 since DEPTH is a power of two
                    if (fa == last_q) begin
                        pc_d = '0;
                        if (WRAP == 0) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        pc_d = fa + PC_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            issued_q <= issued_d;
        end
    end

    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.issued      = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_fetch_unit
//  Brief    : Self-checking bench: halt, wrap and saturating-counter instances.
//  Revision : 1.0
// ============================================================================
module tb_prog_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] prog_last;
    logic       start;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       ready;

    always #5 clk = ~clk;

    prog_fetch_unit_if #(.INSTR_W(8), .PC_W(4), .CNT_W(16)) if0 (), if1 ();
    prog_fetch_unit_if #(.INSTR_W(8), .PC_W(4), .CNT_W(3))  if2 ();

    assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;     assign if2.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data; assign if2.wr_data = wr_data;
    assign if0.prog_last = prog_last; assign if1.prog_last = prog_last; assign if2.prog_last = prog_last;
    assign if0.start = start;     assign if1.start = start;     assign if2.start = start;
    assign if0.jump_en = jump_en; assign if1.jump_en = jump_en; assign if2.jump_en = jump_en;
    assign if0.jump_addr = jump_addr; assign if1.jump_addr = jump_addr; assign if2.jump_addr = jump_addr;
    assign if0.instr_ready = ready; assign if1.instr_ready = ready; assign if2.instr_ready = ready;

    prog_fetch_unit #(.INSTR_W(8), .DEPTH(16), .PC_W(4), .WRAP(0), .CNT_W(16)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    prog_fetch_unit #(.INSTR_W(8), .DEPTH(16), .PC_W(4), .WRAP(1), .CNT_W(16)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    prog_fetch_unit #(.INSTR_W(8), .DEPTH(16), .PC_W(4), .WRAP(1), .CNT_W(3)) u_dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    // sel picks which instance (halt or wrap) the stream model follows
    logic        sel;
    logic [7:0]  o_instr;
    logic [3:0]  o_pc;
    logic        o_valid, o_busy, o_done;
    logic [15:0] o_issued;

    always_comb begin
        o_instr  = sel ? if1.instr       : if0.instr;
        o_pc     = sel ? if1.instr_pc    : if0.instr_pc;
        o_valid  = sel ? if1.instr_valid : if0.instr_valid;
        o_busy   = sel ? if1.busy        : if0.busy;
        o_done   = sel ? if1.done        : if0.done;
        o_issued = sel ? if1.issued      : if0.issued;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem_m [16];
    int         exp_addr;
    int         m_issued;
    int         m_last;
    bit         m_wrap;
    bit         m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; accepted instructions are compared with the
    // program stream expected from the current model position.
    task automatic tick(input bit rdy, input bit jmp, input logic [3:0] ja);
        bit         hs;
        bit         stall;
        logic [7:0] prev_instr;
        logic [3:0] prev_pc;
        ready      = rdy;
        jump_en    = jmp;
        jump_addr  = ja;
        hs         = o_valid && rdy;
        stall      = o_valid && !rdy;
        prev_instr = o_instr;
        prev_pc    = o_pc;
        if (hs) begin
            chk("stream_pc", {28'd0, o_pc}, exp_addr);
            chk("stream_instr", {24'd0, o_instr}, {24'd0, mem_m[exp_addr]});
            m_issued++;
            if (jmp) exp_addr = int'(ja);
            else if (exp_addr == m_last) begin
                if (m_wrap) exp_addr = 0;
                else        m_done = 1'b1;
            end else exp_addr = (exp_addr + 1) % 16;
        end
        @(posedge clk); #1;
        jump_en = 1'b0;
        if (stall) begin
            chk("stall_instr", {24'd0, o_instr}, {24'd0, prev_instr});
            chk("stall_pc", {28'd0, o_pc}, {28'd0, prev_pc});
        end
        chk("valid", {31'd0, o_valid}, {31'd0, !m_done});
        chk("done", {31'd0, o_done}, {31'd0, m_done});
        chk("busy", {31'd0, o_busy}, {31'd0, !m_done});
        chk("issued", {16'd0, o_issued}, m_issued);
    endtask

    task automatic do_start(input logic [3:0] last);
        prog_last = last;
        start     = 1'b1;
        ready     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_addr = 0;
        m_last   = int'(last);
        m_done   = 1'b0;
        m_issued = 0;
        chk("start_busy", {31'd0, o_busy}, 32'd1);
        chk("start_valid", {31'd0, o_valid}, 32'd0);
        chk("start_done", {31'd0, o_done}, 32'd0);
        chk("start_issued", {16'd0, o_issued}, 32'd0);
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready
    task automatic run_to_done(input int mode);
        bit rdy;
        for (int n = 0; n < 200 && !m_done; n++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 4 == 0) || (n % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tick(rdy, 1'b0, 4'd0);
        end
        chk("reach_done", {31'd0, o_done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_instr"}, {24'd0, o_instr}, 32'd0);
        chk({tag, "_pc"}, {28'd0, o_pc}, 32'd0);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_issued"}, {16'd0, o_issued}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_last = '0;
        start = 1'b0; jump_en = 1'b0; jump_addr = '0; ready = 1'b0;
        sel = 1'b0; m_wrap = 1'b0; m_done = 1'b0; m_issued = 0; exp_addr = 0; m_last = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Load program while idle.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'h10 + 8'(i);
            mem_m[i] = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        check_reset_values("reset");

        // Halt mode, free-flowing, then ready pattern, then random ready.
        do_start(4'd3);
        run_to_done(0);
        chk("t1_issued", {16'd0, o_issued}, 32'd4);
        do_start(4'd3);
        run_to_done(1);
        do_start(4'd6);
        run_to_done(2);

        // Single-instruction program.
        do_start(4'd0);
        run_to_done(2);
        chk("single_issued", {16'd0, o_issued}, 32'd1);

        // Write colliding with the fetch of address 2 returns the old data.
        do_start(4'd3);
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        chk("coll_pc", {28'd0, o_pc}, 32'd1);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hAA;
        tick(1'b1, 1'b0, 4'd0);
        wr_en = 1'b0;
        run_to_done(0);
        mem_m[2] = 8'hAA;
        do_start(4'd3);
        run_to_done(0);

        // Asynchronous reset in mid-run.
        do_start(4'd7);
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        check_reset_values("post_rst");
        do_start(4'd7);
        run_to_done(2);

        // Wrap mode on the wrap instances.
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sel = 1'b1; m_wrap = 1'b1;
        do_start(4'd15);
        for (int i = 0; i < 21; i++) tick(1'b1, 1'b0, 4'd0);
        chk("wrap_issued", {16'd0, o_issued}, 32'd20);
        chk("sat_issued", {29'd0, if2.issued}, 32'd7);

        // Jump taken on an accepted pc=1, then jump ignored during a stall.
        n = 0;
        while (!(o_valid && o_pc == 4'd1) && n < 40) begin
            tick(1'b1, 1'b0, 4'd0);
            n++;
        end
        chk("wait_pc1", {31'd0, o_valid && o_pc == 4'd1}, 32'd1);
        tick(1'b1, 1'b1, 4'd9);
        chk("jump_pc", {28'd0, o_pc}, 32'd9);
        chk("jump_instr", {24'd0, o_instr}, 32'h19);
        tick(1'b0, 1'b1, 4'd5);
        tick(1'b1, 1'b0, 4'd0);
        chk("after_jump_pc", {28'd0, o_pc}, 32'd10);

        // Random ready and jumps in wrap mode.
        for (int i = 0; i < 80; i++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
        end
        chk("sat_hold", {29'd0, if2.issued}, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
